tick_sched: RTL

Programmable tick scheduler that replaces derived-clock dividers with single-cycle clock-enable strobes in the `clk_100m` domain. A shared prescaler produces a base tick (default 1 MHz). N independent channels count base ticks and emit periodic or one-shot strobes. Channels are configured at runtime through a valid/ready write port. Downstream logic (display scan, debounce, UART baud, timers) consumes `tick[i]` as an enable and never as a clock.

---
 rtl/tick_sched_pkg.sv | 20 ++
 rtl/tick_chan.sv | 70 +++++++
 rtl/tick_sched.sv | 81 ++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types and helpers for the tick scheduler
package tick_sched_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Widest channel divisor the config struct can carry; channels use the low DIV_W bits.
  localparam int DIV_W_MAX = 32;

  typedef struct packed {
    logic [DIV_W_MAX-1:0] div;
    logic                 mode;
    logic                 en;
  } chan_cfg_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one scheduler channel: counts base ticks, emits a registered strobe
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      base_tick_i,
  input  logic      wr_i,
  input  chan_cfg_t cfg_i,
  output logic      tick_o,
  output logic      busy_o
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             mode_q;
  logic             tick_q;
  logic [DIV_W-1:0] wr_div;

  assign wr_div = cfg_i.div[DIV_W-1:0];

  if (DIV_W < DIV_W_MAX) begin : g_hi
    logic unused_div_hi;
    assign unused_div_hi = ^cfg_i.div[DIV_W_MAX-1:DIV_W];
  end

  // Writes and base-tick evaluation never share an edge (cfg_ready gating), so the write branch wins freely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_PERIODIC;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (wr_i) begin
        if (cfg_i.en && (wr_div != '0)) begin
          div_q   <= wr_div;
          mode_q  <= cfg_i.mode;
          cnt_q   <= wr_div - DIV_W'(1);
          state_q <= S_RUN;
        end else begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      end else if (base_tick_i && (state_q == S_RUN)) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - DIV_W'(1);
        end else begin
          tick_q <= 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            cnt_q <= div_q - DIV_W'(1);
          end else begin
            state_q <= S_IDLE;
          end
        end
      end
    end
  end

  assign tick_o = tick_q;
  assign busy_o = (state_q == S_RUN);

endmodule

// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - shared prescaler, config handshake and per-channel tick strobes
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter  int CLK_HZ  = 100_000_000,
  parameter  int BASE_HZ = 1_000_000,
  parameter  int N_CH    = 4,
  parameter  int DIV_W   = 16,
  localparam int CH_W    = ch_w(N_CH)
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic             cfg_en,
  output logic             base_tick,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);

  localparam int PRE    = CLK_HZ / BASE_HZ;
  localparam int PCNT_W = $clog2(PRE);

  if (CLK_HZ % BASE_HZ != 0) begin : g_bad_ratio
    $error("tick_sched: CLK_HZ must be an integer multiple of BASE_HZ");
  end
  if (PRE < 2) begin : g_bad_pre
    $error("tick_sched: CLK_HZ/BASE_HZ must be at least 2");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("tick_sched: N_CH must be at least 1");
  end
  if (DIV_W > DIV_W_MAX || DIV_W < 1) begin : g_bad_divw
    $error("tick_sched: DIV_W out of range");
  end

  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;
  logic              accept;
  chan_cfg_t         cfg;

  assign base_tick = (pcnt_q == PCNT_W'(PRE - 1));
  assign pcnt_d    = base_tick ? '0 : pcnt_q + PCNT_W'(1);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // Refusing writes on base-tick cycles keeps config updates and channel evaluation on separate edges.
  assign cfg_ready = ~base_tick;
  assign accept    = cfg_valid & cfg_ready;

  assign cfg.div  = DIV_W_MAX'(cfg_div);
  assign cfg.mode = cfg_mode;
  assign cfg.en   = cfg_en;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;
    assign wr = accept && (cfg_ch == CH_W'(i));

    tick_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk_i       (clk_100m),
      .rst_ni      (rst_n),
      .base_tick_i (base_tick),
      .wr_i        (wr),
      .cfg_i       (cfg),
      .tick_o      (tick[i]),
      .busy_o      (busy[i])
    );
  end

endmodule
